// File: rtl/sdma_arb_pkg.sv
// Shared types and defaults for the SDMA request arbiter.
package sdma_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible bit above ptr, wrapping.
// Generic enough to arbitrate message or interrupt sources as well.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               any_valid
);

    logic [PTR_W-1:0] cand;

    // Walk offsets from farthest to nearest so the closest eligible
    // requester after ptr is the last (and therefore surviving) assignment.
    always_comb begin
        // NOTE: every output gets a default before the loop; without it a
        // path that finds no eligible bit would hold the old value (latch).
        winner_oh  = '0;
        winner_idx = '0;
        any_valid  = 1'b0;
        cand       = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = PTR_W'((int'(ptr) + off) % NUM_REQ);
            if (eligible[cand]) begin
                winner_oh       = '0;
                winner_oh[cand] = 1'b1;
                winner_idx      = cand;
                any_valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdma_req_arbiter.sv
// Round-robin sharing of one SDMA macro channel between NUM_REQ requesters.
// Optional grant watchdog enabled by defining SDMA_ARB_TIMEOUT_EN.
module sdma_req_arbiter
    import sdma_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TMR_W          = 13
) (
    input  logic               WB_CLK,
    input  logic               WB_RST,
    input  logic [NUM_REQ-1:0] Req_i,
    input  logic [NUM_REQ-1:0] Sreq_i,
    input  logic [NUM_REQ-1:0] Req_En_i,
    output logic [NUM_REQ-1:0] Grant_o,
    output logic [NUM_REQ-1:0] Done_o,
    output logic [NUM_REQ-1:0] Active_o,
    output logic               Busy_o,
    output logic               SDMA_Req_o,
    output logic               SDMA_Sreq_o,
    input  logic               SDMA_Active_i,
    input  logic               SDMA_Done_i,
    input  logic               Err_Clr_i,
    output logic               Timeout_Intr_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] done_q;
    logic [PTR_W-1:0]   ptr;
    logic               sdma_req;
    logic               sdma_sreq;
    logic [NUM_REQ-1:0] win_oh;
    logic [PTR_W-1:0]   win_idx;
    logic               any_valid;
    logic               owner_req;
    logic               expire;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .eligible   (Req_i & Req_En_i),
        .ptr        (ptr),
        .winner_oh  (win_oh),
        .winner_idx (win_idx),
        .any_valid  (any_valid)
    );

    assign owner_req = |(Req_i & grant);

    // NOTE: synchronous reset lives inside the clocked block and all state is
    // written with <= so every register sees pre-edge values of the others.
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state     <= ST_IDLE;
            grant     <= '0;
            done_q    <= '0;
            ptr       <= PTR_W'(NUM_REQ - 1);
            sdma_req  <= 1'b0;
            sdma_sreq <= 1'b0;
        end else begin
            done_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant     <= win_oh;
                        ptr       <= win_idx;
                        sdma_req  <= 1'b1;
                        sdma_sreq <= Sreq_i[win_idx];
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Completion beats watchdog, which beats the normal handshake.
                    if (SDMA_Done_i) begin
                        sdma_req  <= 1'b0;
                        sdma_sreq <= 1'b0;
                        done_q    <= grant;
                        state     <= ST_DONE;
                    end else if (expire || !(SDMA_Active_i || owner_req)) begin
                        sdma_req  <= 1'b0;
                        sdma_sreq <= 1'b0;
                        grant     <= '0;
                        state     <= ST_IDLE;
                    end else if (SDMA_Active_i) begin
                        sdma_req  <= 1'b0;
                        sdma_sreq <= 1'b0;
                        state     <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (SDMA_Done_i) begin
                        done_q <= grant;
                        state  <= ST_DONE;
                    end else if (expire) begin
                        grant <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SDMA_ARB_TIMEOUT_EN
    logic [TMR_W-1:0] tmr;
    logic             to_flag;

    assign expire = (state == ST_REQ || state == ST_ACTIVE) &&
                    (tmr == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            tmr     <= '0;
            to_flag <= 1'b0;
        end else begin
            tmr <= (state == ST_IDLE) ? '0 : tmr + 1'b1;
            if (expire && !SDMA_Done_i)
                to_flag <= 1'b1;
            else if (Err_Clr_i)
                to_flag <= 1'b0;
        end
    end

    assign Timeout_Intr_o = to_flag;
`else
    logic             unused_err_clr;
    logic [TMR_W-1:0] unused_tmr_cfg;

    assign expire         = 1'b0;
    assign Timeout_Intr_o = 1'b0;
    assign unused_err_clr = Err_Clr_i;
    assign unused_tmr_cfg = TMR_W'(TIMEOUT_CYCLES);
`endif

    assign Grant_o     = grant;
    assign Done_o      = done_q;
    assign Active_o    = grant & {NUM_REQ{SDMA_Active_i}};
    assign Busy_o      = (state != ST_IDLE);
    assign SDMA_Req_o  = sdma_req;
    assign SDMA_Sreq_o = sdma_sreq;

endmodule
